// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and constants for the round-robin mux arbiter.
package rr_mux_arbiter_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_mux_arbiter_rr_pick.sv
// Rotated priority pick: first set bit of valid starting at ptr, wrapping mod 4.
module rr_pick
  import rr_mux_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] valid,
  input  logic [1:0]         ptr,
  output logic [1:0]         index,
  output logic               any
);

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    logic [1:0] cand;
    index = ptr;
    any   = |valid;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (valid[cand]) index = cand;
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Four-way round-robin arbiter muxing one requester at a time onto a single
// valid/ready output, holding each grant for up to MAX_BURST beats.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_REQ-1:0]  in_valid,
  input  logic [WIDTH-1:0]    in0,
  input  logic [WIDTH-1:0]    in1,
  input  logic [WIDTH-1:0]    in2,
  input  logic [WIDTH-1:0]    in3,
  output logic [NUM_REQ-1:0]  in_ready,
  output logic                out_valid,
  output logic [WIDTH-1:0]    out_data,
  input  logic                out_ready,
  output logic [1:0]          grant_sel,
  output logic                busy
);

  // One extra bit so MAX_BURST==1 still yields a legal, nonzero width.
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  state_t             state, state_nxt;
  logic [1:0]         ptr, ptr_nxt;
  logic [1:0]         sel_nxt;
  logic [CNT_W-1:0]   beat_cnt, beat_cnt_nxt;

  logic [1:0]         pick_idx;
  logic               pick_any;
  logic               sel_valid;
  logic               xfer;
  logic [NUM_REQ-1:0][WIDTH-1:0] ins;

  rr_pick u_pick (
    .valid (in_valid),
    .ptr   (ptr),
    .index (pick_idx),
    .any   (pick_any)
  );

  assign ins       = {in3, in2, in1, in0};
  assign busy      = (state == GRANT);
  assign sel_valid = in_valid[grant_sel];
  assign out_valid = busy && sel_valid;
  assign out_data  = ins[grant_sel];
  assign xfer      = out_valid && out_ready;

  // Only the granted requester sees downstream ready; everyone else is held off.
  always_comb begin
    in_ready = '0;
    if (busy) in_ready[grant_sel] = out_ready;
  end

  // Next-state: arbitrate in IDLE, count beats and release in GRANT.
  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    sel_nxt      = grant_sel;
    beat_cnt_nxt = beat_cnt;
    unique case (state)
      IDLE: begin
        if (pick_any) begin
          sel_nxt   = pick_idx;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        // Requester dropping valid or finishing its burst both end the grant.
        if (!sel_valid || (xfer && beat_cnt == LAST_BEAT)) begin
          state_nxt    = IDLE;
          ptr_nxt      = grant_sel + 2'd1;
          beat_cnt_nxt = '0;
        end else if (xfer) begin
          beat_cnt_nxt = beat_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      grant_sel <= '0;
      beat_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      grant_sel <= sel_nxt;
      beat_cnt  <= beat_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench: driver pushes expected per-cycle status and expected
// beats from a behavioural model; a negedge monitor pops and compares.
module tb_rr_mux_arbiter;

  localparam int W  = 8;
  localparam int MB = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   in_valid;
  logic [W-1:0] in0, in1, in2, in3;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic [1:0]   grant_sel;
  logic         busy;

  rr_mux_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .grant_sel(grant_sel), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic [1:0] sel;
    logic       ovld;
    logic [3:0] rdy;
  } status_t;

  typedef struct packed {
    logic [1:0]   sel;
    logic [W-1:0] data;
  } beat_t;

  status_t st_q[$];
  beat_t   bt_q[$];

  int vectors = 0;
  int miscompares = 0;
  bit armed = 0;

  // Behavioural model: who owns the output, how many beats done, next start.
  bit m_busy;
  int m_owner;
  int m_beats;
  int m_ptr;

  function automatic void model_reset();
    m_busy = 0; m_owner = 0; m_beats = 0; m_ptr = 0;
  endfunction

  task automatic check(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, record expectations for it, then advance the model.
  task automatic drive(input bit rst, input logic [3:0] v, input bit rdy);
    logic [W-1:0] d[4];
    status_t s;
    beat_t   b;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) d[i] = W'($urandom);
    rst_n = ~rst; in_valid = v; out_ready = rdy;
    in0 = d[0]; in1 = d[1]; in2 = d[2]; in3 = d[3];
    s.busy = m_busy;
    s.sel  = 2'(m_owner);
    s.ovld = m_busy && v[m_owner];
    s.rdy  = m_busy ? (4'(rdy) << m_owner) : 4'b0;
    st_q.push_back(s);
    armed = 1;
    if (s.ovld && rdy) begin
      b.sel = 2'(m_owner); b.data = d[m_owner];
      bt_q.push_back(b);
    end
    if (rst) begin
      model_reset();
    end else if (!m_busy) begin
      if (v != 0) begin
        for (int k = 0; k < 4; k++)
          if (v[(m_ptr + k) % 4]) begin m_owner = (m_ptr + k) % 4; break; end
        m_busy = 1;
      end
    end else if (!v[m_owner]) begin
      m_busy = 0; m_ptr = (m_owner + 1) % 4; m_beats = 0;
    end else if (rdy) begin
      m_beats++;
      if (m_beats == MB) begin
        m_busy = 0; m_ptr = (m_owner + 1) % 4; m_beats = 0;
      end
    end
  endtask

  // Monitor: compare status every armed cycle, and every presented beat.
  initial begin
    status_t s;
    beat_t   b;
    forever begin
      @(negedge clk);
      if (armed) begin
        if (st_q.size() == 0) begin
          check("status_queue_empty", 0, 1);
        end else begin
          s = st_q.pop_front();
          check("busy", int'(busy), int'(s.busy));
          check("grant_sel", int'(grant_sel), int'(s.sel));
          check("out_valid", int'(out_valid), int'(s.ovld));
          check("in_ready", int'(in_ready), int'(s.rdy));
        end
        if (out_valid && out_ready) begin
          if (bt_q.size() == 0) begin
            check("unexpected_beat", 1, 0);
          end else begin
            b = bt_q.pop_front();
            check("beat_sel", int'(grant_sel), int'(b.sel));
            check("beat_data", int'(out_data), int'(b.data));
          end
        end
      end
    end
  end

  initial begin
    logic [3:0] v;
    rst_n = 1'b0; in_valid = '0; out_ready = 1'b0;
    in0 = '0; in1 = '0; in2 = '0; in3 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    // Reset then single requester 2.
    drive(1, 4'b0000, 1);
    repeat (4) drive(0, 4'b0100, 1);
    drive(0, 4'b0000, 1);
    drive(1, 4'b0000, 1);
    // Fairness: all valid, ready high.
    repeat (26) drive(0, 4'b1111, 1);
    drive(0, 4'b0000, 1);
    // Early release from requester 1, then only 3 left.
    drive(1, 4'b0000, 1);
    drive(0, 4'b0010, 0);
    drive(0, 4'b0010, 0);
    drive(0, 4'b1010, 1);
    drive(0, 4'b1010, 1);
    repeat (6) drive(0, 4'b1000, 1);
    // Stall mid-burst then reset mid-grant.
    drive(0, 4'b0001, 1);
    drive(0, 4'b0001, 1);
    repeat (5) drive(0, 4'b0001, 0);
    drive(0, 4'b0001, 1);
    drive(1, 4'b0001, 1);
    drive(0, 4'b0001, 1);
    // Randomized traffic with sticky valids and occasional reset.
    v = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 3) == 0) v[i] = ~v[i];
      drive($urandom_range(0, 199) == 0, v, $urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    #1;
    check("beats_left", bt_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
